pipe_stage_reg: RTL

Parametrised, flushable pipeline stage register with a valid/ready handshake and an optional skid slot. It is the next generation of the fixed-field inter-stage latches: each instance carries one control bundle and one data bundle between two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds backpressure (stall), flush (bubble insertion) and full throughput under registered ready.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 34 +++
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline stage registers.
// Holds the stage occupancy enum and the control-field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int WB_W = 2;
  localparam int M_W  = 2;
  localparam int EX_W = 4;

  localparam int CTRL_W_DEF = WB_W + M_W + EX_W;
  localparam int DATA_W_DEF = 101;

  function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
    input logic [WB_W-1:0] wb,
    input logic [M_W-1:0]  m,
    input logic [EX_W-1:0] ex
  );
    return {wb, m, ex};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data register with load and clear-to-bubble.
// Clear wins over load; clear keeps the payload and bubbles ctrl.
module pipe_slot #(
  parameter int                CTRL_W      = 8,
  parameter int                DATA_W      = 101,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= CTRL_BUBBLE;
      data_o  <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= CTRL_BUBBLE;
    end else if (load_i) begin
      valid_o <= 1'b1;
      ctrl_o  <= ctrl_i;
      data_o  <= data_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flushable valid/ready pipeline stage register.
// Optional skid slot enabled by PIPE_STAGE_SKID_EN (registered ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
);

  pipe_state_e state_q, state_d;

  logic              accept, consume;
  logic              main_ld, main_clr;
  logic              main_v;
  logic [CTRL_W-1:0] main_c, main_c_in;
  logic [DATA_W-1:0] main_d, main_d_in;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_ld, skid_clr, main_from_skid;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_c;
  logic [DATA_W-1:0] skid_d;

  // Ready comes straight from the skid valid flop.
  assign in_ready_o = ~skid_v;
  assign main_c_in  = main_from_skid ? skid_c : in_ctrl_i;
  assign main_d_in  = main_from_skid ? skid_d : in_data_i;
`else
  assign in_ready_o = out_ready_i | ~main_v;
  assign main_c_in  = in_ctrl_i;
  assign main_d_in  = in_data_i;
`endif

  assign accept  = in_valid_i & in_ready_o;
  assign consume = main_v & out_ready_i;

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush_i) begin
      main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr = 1'b1;
`endif
      state_d  = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (accept && consume) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (consume) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
`else
          if (accept) begin
            main_ld = 1'b1;
          end else if (consume) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (consume) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (main_ld),
    .clear_i (main_clr),
    .ctrl_i  (main_c_in),
    .data_i  (main_d_in),
    .valid_o (main_v),
    .ctrl_o  (main_c),
    .data_o  (main_d)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_ld),
    .clear_i (skid_clr),
    .ctrl_i  (in_ctrl_i),
    .data_i  (in_data_i),
    .valid_o (skid_v),
    .ctrl_o  (skid_c),
    .data_o  (skid_d)
  );
`endif

  assign out_valid_o = main_v;
  assign out_ctrl_o  = main_v ? main_c : CTRL_BUBBLE;
  assign out_data_o  = main_d;

endmodule
